fm_sb_mon: RTL and testbench

- Monitor/status collector for the spy-buffer (SB) array. It is the return path of the SB control block.
- The control block drives freeze/init requests out to the spy buffers. This block gathers per-SB acknowledges and flags back and reduces them into FM monitor-register fields.
- Provides a freeze-handshake FSM with timeout and latency measurement, an init-memory completion tracker, and sticky overflow/playback-done bits with masked clear.
- Sits in the axi_clk domain between the SB array status wires and the FM_MON register bank.

---
 rtl/fm_sb_pkg.sv | 20 ++
 rtl/fm_sb_mon_if.sv | 44 ++++
 rtl/fm_sb_sticky_word.sv | 17 +
 rtl/fm_sb_mon.sv | 186 ++++++++++++++++++
 tb/tb_fm_sb_mon.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the spy-buffer monitor slice: freeze FSM states,
// word-count constants and the clear-select width helper.
package fm_sb_pkg;
  localparam int SB_N_DEF       = 128;
  localparam int AXI_DW_DEF     = 32;
  localparam int SB_WORDS       = SB_N_DEF / AXI_DW_DEF;
  localparam int FREEZE_TMO_DEF = 4096;

  typedef enum logic [1:0] {
    FM_IDLE     = 2'd0,
    FM_FREEZING = 2'd1,
    FM_FROZEN   = 2'd2,
    FM_TIMEOUT  = 2'd3
  } freeze_state_e;

  // A single clear-word still needs a one-bit select port.
  function automatic int sel_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/fm_sb_mon_if.sv
// SB array status wires and FM_MON register fields seen by the monitor.
// master = SB array / register side, slave = the monitor itself.
interface fm_sb_mon_if
  import fm_sb_pkg::*;
#(
  parameter int SB_N   = SB_WORDS * AXI_DW_DEF,
  parameter int AXI_DW = AXI_DW_DEF,
  parameter int TMO_W  = 16
);
  localparam int SEL_W = sel_w(SB_N / AXI_DW);

  logic [SB_N-1:0]   freeze_req;
  logic              init_spy_mem;
  logic [SB_N-1:0]   sb_frozen;
  logic [SB_N-1:0]   sb_init_done;
  logic [SB_N-1:0]   sb_overflow;
  logic [SB_N-1:0]   sb_pb_done;
  logic              clr_stb;
  logic [SEL_W-1:0]  clr_sel;
  logic [AXI_DW-1:0] clr_mask;

  logic [1:0]        freeze_state;
  logic [TMO_W-1:0]  freeze_latency;
  logic [SB_N-1:0]   freeze_missing;
  logic              init_busy;
  logic              init_done;
  logic [SB_N-1:0]   ovf_sticky;
  logic [SB_N-1:0]   pb_done_sticky;
  logic [15:0]       ovf_count;

  modport master (
    output freeze_req, init_spy_mem, sb_frozen, sb_init_done, sb_overflow,
           sb_pb_done, clr_stb, clr_sel, clr_mask,
    input  freeze_state, freeze_latency, freeze_missing, init_busy, init_done,
           ovf_sticky, pb_done_sticky, ovf_count
  );

  modport slave (
    input  freeze_req, init_spy_mem, sb_frozen, sb_init_done, sb_overflow,
           sb_pb_done, clr_stb, clr_sel, clr_mask,
    output freeze_state, freeze_latency, freeze_missing, init_busy, init_done,
           ovf_sticky, pb_done_sticky, ovf_count
  );
endinterface

// File: rtl/fm_sb_sticky_word.sv
// One register word of sticky event bits; a set in the same cycle as a masked
// clear keeps the bit set so no event is lost.
module fm_sb_sticky_word #(
  parameter int W = 32
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] set_vec,
  input  logic         clr,
  input  logic [W-1:0] mask,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= (clr ? (q & ~mask) : q) | set_vec;
  end
endmodule

// File: rtl/fm_sb_mon.sv
// Return-path monitor for the spy-buffer array: freeze handshake FSM with
// timeout/latency, init-memory tracker, sticky overflow/playback bits, overflow count.
module fm_sb_mon
  import fm_sb_pkg::*;
#(
  parameter int SB_N       = SB_WORDS * AXI_DW_DEF,
  parameter int AXI_DW     = AXI_DW_DEF,
  parameter int TMO_W      = 16,
  parameter int FREEZE_TMO = FREEZE_TMO_DEF
)(
  input logic        axi_clk,
  input logic        axi_reset_n,
  fm_sb_mon_if.slave sb
);
  localparam int WORDS = SB_N / AXI_DW;
  localparam int SEL_W = sel_w(WORDS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FREEZE_TMO - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) rst_sync <= '0;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Stage p0: every input registered once
  logic [SB_N-1:0]   req_p0, frozen_p0, init_done_p0, ovf_p0, pb_p0;
  logic              init_p0, init_p1, clr_stb_p0;
  logic [SEL_W-1:0]  clr_sel_p0;
  logic [AXI_DW-1:0] clr_mask_p0;

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_p0       <= '0;
      frozen_p0    <= '0;
      init_done_p0 <= '0;
      ovf_p0       <= '0;
      pb_p0        <= '0;
      init_p0      <= 1'b0;
      init_p1      <= 1'b0;
      clr_stb_p0   <= 1'b0;
      clr_sel_p0   <= '0;
      clr_mask_p0  <= '0;
    end else begin
      req_p0       <= sb.freeze_req;
      frozen_p0    <= sb.sb_frozen;
      init_done_p0 <= sb.sb_init_done;
      ovf_p0       <= sb.sb_overflow;
      pb_p0        <= sb.sb_pb_done;
      init_p0      <= sb.init_spy_mem;
      init_p1      <= init_p0;
      clr_stb_p0   <= sb.clr_stb;
      clr_sel_p0   <= sb.clr_sel;
      clr_mask_p0  <= sb.clr_mask;
    end
  end

  // Stage p1: status registers driving the monitor fields
  freeze_state_e    state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d, lat_q, lat_d;
  logic [SB_N-1:0]  miss_q, miss_d;
  logic             all_acked;

  assign all_acked = (frozen_p0 & req_p0) == req_p0;

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FM_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    miss_d  = miss_q;
    if (req_p0 == '0) begin
      state_d = FM_IDLE;
    end else begin
      case (state_q)
        FM_IDLE: begin
          state_d = FM_FREEZING;
          cnt_d   = '0;
          miss_d  = '0;
        end
        FM_FREEZING: begin
          cnt_d = cnt_q + TMO_W'(1);
          if (all_acked) begin
            state_d = FM_FROZEN;
            lat_d   = cnt_q;
          end else if (cnt_q == TMO_LAST) begin
            state_d = FM_TIMEOUT;
            miss_d  = req_p0 & ~frozen_p0;
            lat_d   = '1;
          end
        end
        // A lost ack resumes counting where the last freeze finished.
        FM_FROZEN: begin
          if (!all_acked) begin
            state_d = FM_FREEZING;
            cnt_d   = lat_q;
          end
        end
        FM_TIMEOUT: begin
          if (all_acked) state_d = FM_FROZEN;
        end
        default: state_d = FM_IDLE;
      endcase
    end
  end

  logic busy_q, done_q, init_rise, done_clr;

  assign init_rise = init_p0 & ~init_p1;
  // init_done shares the clear bit with ovf_sticky[AXI_DW-1] of word 0.
  assign done_clr  = clr_stb_p0 && (clr_sel_p0 == '0) && clr_mask_p0[AXI_DW-1];

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (done_clr) done_q <= 1'b0;
      if (busy_q) begin
        if (&init_done_p0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (init_rise) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end
    end
  end

  logic [SB_N-1:0] ovf_q, pb_q;

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic clr_w;
    assign clr_w = clr_stb_p0 && (clr_sel_p0 == SEL_W'(w));

    fm_sb_sticky_word #(.W(AXI_DW)) u_ovf (
      .clk(axi_clk), .rst_n(rst_n), .set_vec(ovf_p0[w*AXI_DW +: AXI_DW]),
      .clr(clr_w), .mask(clr_mask_p0), .q(ovf_q[w*AXI_DW +: AXI_DW])
    );
    fm_sb_sticky_word #(.W(AXI_DW)) u_pb (
      .clk(axi_clk), .rst_n(rst_n), .set_vec(pb_p0[w*AXI_DW +: AXI_DW]),
      .clr(clr_w), .mask(clr_mask_p0), .q(pb_q[w*AXI_DW +: AXI_DW])
    );
  end

  logic [15:0] ovf_cnt_q;
  logic        ovf_any, full_clr;

  assign ovf_any  = |ovf_p0;
  assign full_clr = clr_stb_p0 && (&clr_mask_p0);

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n)       ovf_cnt_q <= '0;
    else if (full_clr) ovf_cnt_q <= ovf_any ? 16'd1 : 16'd0;
    else if (ovf_any) ovf_cnt_q <= sat_inc16(ovf_cnt_q);
  end

  assign sb.freeze_state   = state_q;
  assign sb.freeze_latency = lat_q;
  assign sb.freeze_missing = miss_q;
  assign sb.init_busy      = busy_q;
  assign sb.init_done      = done_q;
  assign sb.ovf_sticky     = ovf_q;
  assign sb.pb_done_sticky = pb_q;
  assign sb.ovf_count      = ovf_cnt_q;
endmodule

// File: tb/tb_fm_sb_mon.sv
// Directed and randomized checks of fm_sb_mon against expectations derived from
// the monitor's behavioural rules (2-cycle input-to-status latency).
module tb_fm_sb_mon;
  import fm_sb_pkg::*;

  localparam int SB_N   = 128;
  localparam int AXI_DW = 32;
  localparam int TMO_W  = 16;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fm_sb_mon_if #(.SB_N(SB_N), .AXI_DW(AXI_DW), .TMO_W(TMO_W)) sbif ();

  fm_sb_mon #(.SB_N(SB_N), .AXI_DW(AXI_DW), .TMO_W(TMO_W), .FREEZE_TMO(TMO)) dut (
    .axi_clk(clk),
    .axi_reset_n(rst_n),
    .sb(sbif)
  );

  int tests = 0;
  int fails = 0;

  logic [SB_N-1:0] m_ovf, m_pb, p_ovf, p_pb, v, low64, bit5;
  logic [15:0]     m_cnt, p_cnt;
  int              d, r, sel;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] sparse();
    logic [127:0] s;
    for (int w = 0; w < 4; w++) s[w*32 +: 32] = $urandom & $urandom & $urandom;
    return s;
  endfunction

  // Sticky/count reference: clear the selected word, then OR in the events.
  task automatic step(input logic [127:0] ovf, input logic [127:0] pb, input logic stb,
                      input logic [1:0] csel, input logic [31:0] mask);
    logic [127:0] cv;
    sbif.sb_overflow = ovf;
    sbif.sb_pb_done  = pb;
    sbif.clr_stb     = stb;
    sbif.clr_sel     = csel;
    sbif.clr_mask    = mask;
    cv = '0;
    if (stb) cv[csel*32 +: 32] = mask;
    m_ovf = (m_ovf & ~cv) | ovf;
    m_pb  = (m_pb & ~cv) | pb;
    if (stb && mask == 32'hFFFF_FFFF) m_cnt = (ovf != '0) ? 16'd1 : 16'd0;
    else if (ovf != '0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    tick(1);
    chk("ovf_sticky", sbif.ovf_sticky, p_ovf);
    chk("pb_done_sticky", sbif.pb_done_sticky, p_pb);
    chk("ovf_count", 128'(sbif.ovf_count), 128'(p_cnt));
    p_ovf = m_ovf;
    p_pb  = m_pb;
    p_cnt = m_cnt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 128'(sbif.freeze_state), 128'(FM_IDLE));
    chk({tag, "_latency"}, 128'(sbif.freeze_latency), 128'd0);
    chk({tag, "_missing"}, sbif.freeze_missing, 128'd0);
    chk({tag, "_busy"}, 128'(sbif.init_busy), 128'd0);
    chk({tag, "_done"}, 128'(sbif.init_done), 128'd0);
    chk({tag, "_ovf"}, sbif.ovf_sticky, 128'd0);
    chk({tag, "_pb"}, sbif.pb_done_sticky, 128'd0);
    chk({tag, "_cnt"}, 128'(sbif.ovf_count), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sbif.freeze_req = '0; sbif.init_spy_mem = 1'b0; sbif.sb_frozen = '0;
    sbif.sb_init_done = '0; sbif.sb_overflow = '0; sbif.sb_pb_done = '0;
    sbif.clr_stb = 1'b0; sbif.clr_sel = '0; sbif.clr_mask = '0;
    m_ovf = '0; m_pb = '0; p_ovf = '0; p_pb = '0; m_cnt = '0; p_cnt = '0;
    low64 = {64'd0, {64{1'b1}}};
    bit5  = 128'd1 << 5;

    tick(3);
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    tick(4);
    chk_all_zero("after_reset");

    // Init tracker: busy until 2 cycles after the last SB reports initialised
    sbif.init_spy_mem = 1'b1; tick(1);
    sbif.init_spy_mem = 1'b0; tick(1);
    chk("init_busy_start", 128'(sbif.init_busy), 128'd1);
    chk("init_done_start", 128'(sbif.init_done), 128'd0);
    for (int c = 0; c < 20; c++) begin
      if (c == 19) sbif.sb_init_done = '1;
      else sbif.sb_init_done = sbif.sb_init_done | (sparse() & {1'b0, {127{1'b1}}});
      sbif.init_spy_mem = (c == 5);
      tick(1);
      chk("init_busy_stagger", 128'(sbif.init_busy), 128'd1);
    end
    tick(1);
    chk("init_busy_end", 128'(sbif.init_busy), 128'd0);
    chk("init_done_set", 128'(sbif.init_done), 128'd1);
    sbif.clr_stb = 1'b1; sbif.clr_sel = 2'd1; sbif.clr_mask = 32'h8000_0000; tick(1);
    sbif.clr_stb = 1'b0; tick(1);
    chk("init_done_wrong_word", 128'(sbif.init_done), 128'd1);
    sbif.clr_stb = 1'b1; sbif.clr_sel = 2'd0; tick(1);
    sbif.clr_stb = 1'b0; tick(1);
    chk("init_done_clr", 128'(sbif.init_done), 128'd0);
    tick(1);

    // Sticky bits and overflow count under random pulses and clears
    for (int i = 0; i < 150; i++) begin
      step(sparse(), sparse(), ($urandom % 4) == 0, 2'($urandom % 4),
           (($urandom % 3) == 0) ? 32'hFFFF_FFFF : $urandom);
    end
    step(128'd1 << 40, '0, 1'b1, 2'd1, 32'h0000_0100);
    step('0, '0, 1'b1, 2'd1, 32'h0000_0100);
    step('0, '0, 1'b0, 2'd0, 32'd0);
    step('0, '0, 1'b0, 2'd0, 32'd0);

    // Freeze all: ack arrives d cycles after the request
    d = 3 + int'($urandom % 18);
    sbif.freeze_req = '1; tick(2);
    chk("frz_enter", 128'(sbif.freeze_state), 128'(FM_FREEZING));
    tick(d - 2);
    sbif.sb_frozen = '1; tick(1);
    chk("frz_wait", 128'(sbif.freeze_state), 128'(FM_FREEZING));
    tick(1);
    chk("frz_frozen", 128'(sbif.freeze_state), 128'(FM_FROZEN));
    chk("frz_latency", 128'(sbif.freeze_latency), 128'(d - 1));
    chk("frz_missing", sbif.freeze_missing, 128'd0);
    r = int'($urandom % 128);
    sbif.sb_frozen[r] = 1'b0; tick(2);
    chk("frz_ack_lost", 128'(sbif.freeze_state), 128'(FM_FREEZING));
    sbif.sb_frozen = '1; tick(2);
    chk("frz_refrozen", 128'(sbif.freeze_state), 128'(FM_FROZEN));
    chk("frz_latency_cont", 128'(sbif.freeze_latency), 128'(d));
    sbif.freeze_req = '0; sbif.sb_frozen = '0; tick(2);
    chk("frz_idle", 128'(sbif.freeze_state), 128'(FM_IDLE));
    chk("frz_latency_held", 128'(sbif.freeze_latency), 128'(d));

    // Timeout: SB 5 never acks within TMO cycles
    sbif.freeze_req = low64; sbif.sb_frozen = low64 & ~bit5; tick(2);
    chk("tmo_enter", 128'(sbif.freeze_state), 128'(FM_FREEZING));
    tick(TMO - 1);
    chk("tmo_last_cycle", 128'(sbif.freeze_state), 128'(FM_FREEZING));
    tick(1);
    chk("tmo_state", 128'(sbif.freeze_state), 128'(FM_TIMEOUT));
    chk("tmo_missing", sbif.freeze_missing, bit5);
    chk("tmo_latency", 128'(sbif.freeze_latency), 128'(16'hFFFF));
    sbif.sb_frozen = low64; tick(2);
    chk("tmo_late_ack", 128'(sbif.freeze_state), 128'(FM_FROZEN));
    chk("tmo_latency_kept", 128'(sbif.freeze_latency), 128'(16'hFFFF));
    sbif.freeze_req = '0; sbif.sb_frozen = '0; tick(2);
    chk("tmo_idle", 128'(sbif.freeze_state), 128'(FM_IDLE));
    chk("tmo_missing_held", sbif.freeze_missing, bit5);

    // Ack landing on the final timeout cycle wins
    sbif.freeze_req = low64; sbif.sb_frozen = low64 & ~bit5; tick(2);
    chk("edge_missing_clr", sbif.freeze_missing, 128'd0);
    tick(TMO - 2);
    sbif.sb_frozen = low64; tick(2);
    chk("edge_ack_wins", 128'(sbif.freeze_state), 128'(FM_FROZEN));
    chk("edge_latency", 128'(sbif.freeze_latency), 128'(TMO - 1));
    sbif.freeze_req = '0; sbif.sb_frozen = '0; tick(2);

    // Asynchronous reset in the middle of a freeze
    sbif.freeze_req = '1; tick(5);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick(2);
    rst_n = 1'b1; tick(3);
    chk("rst_release_idle", 128'(sbif.freeze_state), 128'(FM_IDLE));
    tick(1);
    chk("rst_refreeze", 128'(sbif.freeze_state), 128'(FM_FREEZING));
    sbif.sb_frozen = '1; tick(2);
    chk("rst_frozen", 128'(sbif.freeze_state), 128'(FM_FROZEN));
    chk("rst_latency", 128'(sbif.freeze_latency), 128'd1);
    sbif.freeze_req = '0; sbif.sb_frozen = '0; tick(2);

    // Overflow count saturation and full-mask clear
    sbif.sb_overflow = 128'd1; tick(70000);
    sbif.sb_overflow = '0; tick(2);
    chk("sat_count", 128'(sbif.ovf_count), 128'(16'hFFFF));
    chk("sat_sticky", sbif.ovf_sticky, 128'd1);
    sel = int'($urandom % 4);
    sbif.clr_stb = 1'b1; sbif.clr_sel = 2'(sel); sbif.clr_mask = 32'hFFFF_FFFF; tick(1);
    sbif.clr_stb = 1'b0; tick(1);
    chk("sat_cleared", 128'(sbif.ovf_count), 128'd0);
    chk("sat_sticky_clr", sbif.ovf_sticky, (sel == 0) ? 128'd0 : 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
